cbf_rmw_controller: RTL and testbench

//   Read-modify-write sequencer around blockDecoder for one counting-Bloom-filter memory.

---
 rtl/cbf_rmw_controller.sv | 143 ++++++++++++++
 tb/tb_cbf_rmw_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cbf_rmw_controller.sv
// rtl/cbf_rmw_controller.sv - read-modify-write sequencer for one counting-Bloom-filter block RAM
// One request in flight: read block, evaluate through blockDecoder, optionally write back, then respond.
module cbf_rmw_controller #(
    parameter int NUM_HASHES                 = 6,
    parameter int VECTOR_WIDTH               = 1024,
    parameter int NUM_BITS_TO_ADDRESS_VECTOR = 10,
    parameter int CBF_WIDTH                  = 4,
    parameter int ADDR_WIDTH                 = 10
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [ADDR_WIDTH-1:0]                        in_addr,
    input  logic [NUM_BITS_TO_ADDRESS_VECTOR*NUM_HASHES-1:0] in_hashes,
    input  logic                                         in_insert,
    output logic                                         mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                        mem_rd_addr,
    input  logic [CBF_WIDTH*VECTOR_WIDTH-1:0]            mem_rd_data,
    output logic                                         mem_wr_en,
    output logic [ADDR_WIDTH-1:0]                        mem_wr_addr,
    output logic [CBF_WIDTH*VECTOR_WIDTH-1:0]            mem_wr_data,
    output logic [NUM_BITS_TO_ADDRESS_VECTOR*NUM_HASHES-1:0] dec_hashes,
    output logic [CBF_WIDTH*VECTOR_WIDTH-1:0]            dec_block,
    input  logic [CBF_WIDTH*NUM_HASHES-1:0]              dec_elements,
    input  logic [CBF_WIDTH*VECTOR_WIDTH-1:0]            dec_incremented,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [CBF_WIDTH*NUM_HASHES-1:0]              out_elements,
    output logic                                         out_present,
    output logic                                         out_saturated
);

    localparam int HW = NUM_BITS_TO_ADDRESS_VECTOR * NUM_HASHES;
    localparam int BW = CBF_WIDTH * VECTOR_WIDTH;
    localparam int EW = CBF_WIDTH * NUM_HASHES;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_EVAL = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [HW-1:0]         hash_q, hash_d;
    logic                  ins_q, ins_d;
    logic [BW-1:0]         blk_q, blk_d;
    logic [EW-1:0]         elem_q, elem_d;
    logic                  present_q, present_d;
    logic                  sat_q, sat_d;

    logic                  all_nonzero;
    logic                  any_saturated;

    always_comb begin
        all_nonzero   = 1'b1;
        any_saturated = 1'b0;
        for (int l = 0; l < NUM_HASHES; l++) begin
            if (dec_elements[l*CBF_WIDTH +: CBF_WIDTH] == '0) begin
                all_nonzero = 1'b0;
            end
            if (dec_elements[l*CBF_WIDTH +: CBF_WIDTH] == '1) begin
                any_saturated = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        hash_d    = hash_q;
        ins_d     = ins_q;
        blk_d     = blk_q;
        elem_d    = elem_q;
        present_d = present_q;
        sat_d     = sat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    addr_d  = in_addr;
                    hash_d  = in_hashes;
                    ins_d   = in_insert;
                    state_d = ST_READ;
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                blk_d   = mem_rd_data;
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                elem_d    = dec_elements;
                present_d = all_nonzero;
                sat_d     = any_saturated;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            hash_q    <= '0;
            ins_q     <= 1'b0;
            blk_q     <= '0;
            elem_q    <= '0;
            present_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            hash_q    <= hash_d;
            ins_q     <= ins_d;
            blk_q     <= blk_d;
            elem_q    <= elem_d;
            present_q <= present_d;
            sat_q     <= sat_d;
        end
    end

    // Strobes come from the state register alone, so an async reset in EVAL kills the write at once.
    assign in_ready      = (state_q == ST_IDLE);
    assign mem_rd_en     = (state_q == ST_READ);
    assign mem_rd_addr   = addr_q;
    assign mem_wr_en     = (state_q == ST_EVAL) && ins_q;
    assign mem_wr_addr   = addr_q;
    assign mem_wr_data   = dec_incremented;
    assign dec_hashes    = hash_q;
    assign dec_block     = blk_q;
    assign out_valid     = (state_q == ST_RESP);
    assign out_elements  = elem_q;
    assign out_present   = present_q;
    assign out_saturated = sat_q;

endmodule

// File: tb/tb_cbf_rmw_controller.sv
// tb/tb_cbf_rmw_controller.sv - self-checking bench for cbf_rmw_controller
module tb_cbf_rmw_controller;
    localparam int NH = 2, VW = 16, NB = 4, CW = 4, AW = 4;
    localparam int BW = CW * VW, HW = NB * NH, EW = CW * NH;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_insert;
    logic [AW-1:0] in_addr;
    logic [HW-1:0] in_hashes;
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [BW-1:0] mem_rd_data, mem_wr_data;
    logic [HW-1:0] dec_hashes;
    logic [BW-1:0] dec_block, dec_incremented;
    logic [EW-1:0] dec_elements;
    logic          out_valid, out_ready, out_present, out_saturated;
    logic [EW-1:0] out_elements;

    always #5 clk = ~clk;

    cbf_rmw_controller #(
        .NUM_HASHES(NH), .VECTOR_WIDTH(VW), .NUM_BITS_TO_ADDRESS_VECTOR(NB),
        .CBF_WIDTH(CW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_hashes(in_hashes), .in_insert(in_insert),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .dec_hashes(dec_hashes), .dec_block(dec_block),
        .dec_elements(dec_elements), .dec_incremented(dec_incremented),
        .out_valid(out_valid), .out_ready(out_ready), .out_elements(out_elements),
        .out_present(out_present), .out_saturated(out_saturated)
    );

    // Stand-in blockDecoder: pick addressed counters, saturating increment of each distinct one.
    always_comb begin
        dec_elements    = '0;
        dec_incremented = dec_block;
        for (int l = 0; l < NH; l++) begin
            int idx;
            idx = int'(dec_hashes[l*NB +: NB]);
            dec_elements[l*CW +: CW] = dec_block[idx*CW +: CW];
            if (dec_block[idx*CW +: CW] != 4'hF) begin
                dec_incremented[idx*CW +: CW] = dec_block[idx*CW +: CW] + 4'd1;
            end
        end
    end

    logic [BW-1:0] ram [16];
    int            wr_cnt = 0, rd_cnt = 0;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= ram[mem_rd_addr];
            rd_cnt      <= rd_cnt + 1;
        end
        if (mem_wr_en) begin
            ram[mem_wr_addr] <= mem_wr_data;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    int mcnt [16][16];
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_word(input int a);
        logic [63:0] w;
        for (int i = 0; i < VW; i++) w[i*CW +: CW] = 4'(mcnt[a][i]);
        return w;
    endfunction

    task automatic model_insert(input int a, input int h0, input int h1);
        if (mcnt[a][h0] < 15) mcnt[a][h0]++;
        if (h1 != h0 && mcnt[a][h1] < 15) mcnt[a][h1]++;
    endtask

    task automatic set_cell(input int a, input int idx, input int v);
        ram[a][idx*CW +: CW] <= 4'(v);
        mcnt[a][idx] = v;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_req(input int a, input int h0, input int h1, input bit ins,
                           input int stall, input string tag);
        int e0, e1, lat, wr0, rd0;
        e0 = mcnt[a][h0];
        e1 = mcnt[a][h1];
        @(negedge clk);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        in_addr   = 4'(a);
        in_hashes = {4'(h1), 4'(h0)};
        in_insert = ins;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check({tag, "/latency"}, 64'(lat), 64'd4);
        check({tag, "/elements"}, 64'(out_elements), 64'({4'(e1), 4'(e0)}));
        check({tag, "/present"}, 64'(out_present), 64'(e0 != 0 && e1 != 0));
        check({tag, "/saturated"}, 64'(out_saturated), 64'(e0 == 15 || e1 == 15));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "/stall_hold"}, {55'd0, out_valid, in_ready, out_elements},
                  {55'd0, 1'b1, 1'b0, 4'(e1), 4'(e0)});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "/released"}, 64'({out_valid, in_ready}), 64'b01);
        if (ins) model_insert(a, h0, h1);
        check({tag, "/ram"}, ram[a], model_word(a));
        check({tag, "/writes"}, 64'(wr_cnt - wr0), 64'(ins));
        check({tag, "/reads"}, 64'(rd_cnt - rd0), 64'd1);
    endtask

    initial begin
        int lat, wr0;
        logic [EW-1:0] held_el;
        for (int a = 0; a < 16; a++) begin
            ram[a] <= '0;
            for (int i = 0; i < VW; i++) mcnt[a][i] = 0;
        end
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_hashes = '0; in_insert = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset/ctl", 64'({in_ready, out_valid, mem_rd_en, mem_wr_en}), 64'b1000);
        check("reset/out", 64'({out_elements, out_present, out_saturated}), 64'd0);
        check("reset/dec", 64'(dec_block) | 64'(dec_hashes), 64'd0);

        run_req(3, 2, 5, 1'b1, 0, "t1");
        check("t1/ram3", ram[3], 64'h0000_0000_0010_0100);
        run_req(3, 2, 5, 1'b0, 0, "t2");
        check("t2/el", 64'({out_elements, out_present}), 64'h0_0000_0023);

        set_cell(7, 9, 15);
        run_req(7, 9, 9, 1'b1, 0, "t3");
        check("t3/sat", 64'(out_saturated), 64'd1);
        check("t3/nib9", 64'(ram[7][39:36]), 64'hF);

        // Back-pressure with a second request waiting at the input the whole time.
        @(negedge clk);
        wr0 = wr_cnt;
        in_addr = 4'd5; in_hashes = {4'd3, 4'd1}; in_insert = 1'b1; in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_addr = 4'd6; in_hashes = {4'd4, 4'd4};
        wait_valid(lat);
        check("t4/latency", 64'(lat), 64'd4);
        model_insert(5, 1, 3);
        held_el = out_elements;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            check("t4/hold", {54'd0, out_valid, in_ready, mem_rd_en, mem_wr_en, out_elements},
                  {54'd0, 1'b1, 1'b0, 1'b0, 1'b0, held_el});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t4/idle", 64'({in_ready, out_valid}), 64'b10);
        @(negedge clk);
        in_valid = 1'b0;
        check("t4/accept", 64'({mem_rd_en, mem_rd_addr}), 64'h16);
        wait_valid(lat);
        check("t4/lat2", 64'(lat), 64'd4);
        check("t4/el2", 64'({out_elements, out_saturated}), 64'(mcnt[6][4] == 15 ? 9'h1FF : 9'h0));
        @(negedge clk);
        model_insert(6, 4, 4);
        check("t4/ram5", ram[5], model_word(5));
        check("t4/ram6", ram[6], model_word(6));
        check("t4/writes", 64'(wr_cnt - wr0), 64'd2);

        // Reset asserted in the middle of EVAL of an insert.
        @(negedge clk);
        wr0 = wr_cnt;
        in_addr = 4'd2; in_hashes = {4'd8, 4'd7}; in_insert = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t5/eval_wr", 64'(mem_wr_en), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("t5/wr_drop", 64'({mem_wr_en, mem_rd_en, out_valid, in_ready}), 64'b0001);
        check("t5/outs", 64'({out_elements, out_present, out_saturated}), 64'd0);
        check("t5/dec", 64'(dec_block) | 64'(dec_hashes), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5/ram2", ram[2], model_word(2));
        check("t5/writes", 64'(wr_cnt - wr0), 64'd0);
        run_req(2, 7, 8, 1'b1, 0, "t5b");

        ram[0] <= '0;
        for (int i = 0; i < VW; i++) mcnt[0][i] = 0;
        for (int r = 0; r < 20; r++) begin
            run_req(0, 1, 1, 1'b1, 0, "t6");
            check("t6/sat", 64'(out_saturated), 64'(r >= 15));
            check("t6/nib1", 64'(ram[0][7:4]), 64'(r + 1 > 15 ? 15 : r + 1));
        end

        for (int r = 0; r < 40; r++) begin
            int a, h0, h1;
            a  = int'($urandom_range(8, 11));
            h0 = int'($urandom_range(0, 15));
            h1 = ($urandom_range(0, 3) == 0) ? h0 : int'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) set_cell(a, h0, 14 + int'($urandom_range(0, 1)));
            run_req(a, h0, h1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
